// File: rtl/ppu_update_scheduler_if.sv
// Host write port of the PPU update scheduler: an Avalon-style write-only
// slave bus with a waitrequest stall.
interface ppu_update_scheduler_if;
    logic        chipselect;
    logic        write;
    logic [15:0] address;
    logic [31:0] writedata;
    logic        waitrequest;

    // Host side drives the request and observes the stall.
    modport master (
        output chipselect,
        output write,
        output address,
        output writedata,
        input  waitrequest
    );

    // Scheduler side consumes the request and drives the stall.
    modport slave (
        input  chipselect,
        input  write,
        input  address,
        input  writedata,
        output waitrequest
    );
endinterface

// File: rtl/ppu_update_scheduler.sv
// PPU update scheduler: queues host table writes and commits them to the
// attribute/sprite/color tables only during vertical blanking, one per cycle.
module ppu_update_scheduler #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned VACTIVE = 480,
    parameter int unsigned VLAST   = 524
) (
    input  logic                     clk,
    input  logic                     reset,
    ppu_update_scheduler_if.slave    host,
    input  logic [9:0]               vcount,
    output logic [2:0]               tbl_we,
    output logic [7:0]               tbl_addr,
    output logic [31:0]              tbl_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     bad_addr,
    input  logic                     clear_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = 42;  // {sel[1:0], index[7:0], data[31:0]}

    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [9:0]    V_FIRST    = 10'(VACTIVE);
    localparam logic [9:0]    V_LAST     = 10'(VLAST);

    typedef enum logic [0:0] {IDLE, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            bad_addr_q, bad_addr_d;
    logic [EW-1:0]   mem [DEPTH];

    logic            accept;
    logic            bad_wr;
    logic            push;
    logic            pop;
    logic            window;
    logic [EW-1:0]   entry_in;
    logic [EW-1:0]   head;
    logic [2:0]      head_we;

    // Upper address bits carry no meaning for this block.
    logic unused_addr_hi;
    assign unused_addr_hi = ^host.address[15:10];

    // Stall only on a full queue; derived from the registered level so a
    // same-cycle pop never frees a slot early.
    assign host.waitrequest = (level_q == LEVEL_FULL);

    assign accept   = host.chipselect & host.write & ~host.waitrequest;
    assign bad_wr   = accept & (host.address[9:8] == 2'b11);
    assign push     = accept & ~bad_wr;
    assign entry_in = {host.address[9:8], host.address[7:0], host.writedata};
    assign head     = mem[rptr_q];

    // Line VLAST is left for line-0 sprite evaluation, so it is outside the window.
    assign window = (vcount >= V_FIRST) && (vcount < V_LAST);

    assign level    = level_q;
    assign bad_addr = bad_addr_q;

    // FSM next state and pop decision; the IDLE->DRAIN transition pops at once
    // so an entry accepted into an empty queue reaches the tables two cycles later.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (window && (level_q != '0)) begin
                    state_d = DRAIN;
                    pop     = 1'b1;
                end
            end
            DRAIN: begin
                if (!window || (level_q == '0)) begin
                    state_d = IDLE;
                end else begin
                    pop = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Sticky bad-address flag; a new bad write wins over a clear.
    always_comb begin
        bad_addr_d = bad_addr_q;
        if (bad_wr) begin
            bad_addr_d = 1'b1;
        end else if (clear_err) begin
            bad_addr_d = 1'b0;
        end
    end

    // Decode the head entry's table select into a one-hot write enable.
    always_comb begin
        head_we = 3'b000;
        case (head[41:40])
            2'b00:   head_we = 3'b001;
            2'b01:   head_we = 3'b010;
            2'b10:   head_we = 3'b100;
            default: head_we = 3'b000;
        endcase
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            bad_addr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    // Queue storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= entry_in;
        end
    end

    // Registered table write port: one-cycle enable pulse per popped entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tbl_we   <= 3'b000;
            tbl_addr <= 8'h00;
            tbl_data <= 32'h0000_0000;
        end else begin
            tbl_we <= 3'b000;
            if (pop) begin
                tbl_we   <= head_we;
                tbl_addr <= head[39:32];
                tbl_data <= head[31:0];
            end
        end
    end

endmodule

// File: tb/tb_ppu_update_scheduler.sv
// Directed self-checking bench for ppu_update_scheduler.
module tb_ppu_update_scheduler;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  vcount = 10'd100;
    logic        clear_err = 1'b0;
    logic [2:0]  tbl_we;
    logic [7:0]  tbl_addr;
    logic [31:0] tbl_data;
    logic [4:0]  level;
    logic        bad_addr;

    int vectors = 0;
    int miscompares = 0;

    logic [42:0] obs[$];
    logic [42:0] exp_q[$];

    ppu_update_scheduler_if host_if ();

    ppu_update_scheduler #(
        .DEPTH  (DEPTH),
        .VACTIVE(480),
        .VLAST  (524)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .host     (host_if),
        .vcount   (vcount),
        .tbl_we   (tbl_we),
        .tbl_addr (tbl_addr),
        .tbl_data (tbl_data),
        .level    (level),
        .bad_addr (bad_addr),
        .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    // Capture every table write pulse for in-order comparison.
    always @(negedge clk) begin
        if (!reset && tbl_we != 3'b000) obs.push_back({tbl_we, tbl_addr, tbl_data});
    end

    function automatic logic [42:0] mk(input logic [15:0] a, input logic [31:0] d);
        logic [2:0] we;
        case (a[9:8])
            2'b00:   we = 3'b001;
            2'b01:   we = 3'b010;
            2'b10:   we = 3'b100;
            default: we = 3'b000;
        endcase
        return {we, a[7:0], d};
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic host_write(input logic [15:0] a, input logic [31:0] d);
        bit ok = 0;
        host_if.chipselect = 1'b1;
        host_if.write      = 1'b1;
        host_if.address    = a;
        host_if.writedata  = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (!host_if.waitrequest) ok = 1;
            @(posedge clk);
        end
        #1;
        host_if.chipselect = 1'b0;
        host_if.write      = 1'b0;
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL host_write_timeout addr=%h: waitrequest stayed 1, required accept", a);
        end
    endtask

    task automatic fill16(input logic [31:0] base);
        for (int i = 0; i < 16; i++) begin
            logic [15:0] a;
            a = {6'd0, 2'(i % 3), 8'(i * 7 + 1)};
            host_write(a, base + 32'(i));
            exp_q.push_back(mk(a, base + 32'(i)));
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && level != 0; i++) @(negedge clk);
        vectors++;
        if (level !== 5'd0) begin
            miscompares++;
            $display("FAIL drain_timeout level=%0d required 0", level);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        host_if.chipselect = 1'b0; host_if.write = 1'b0;
        host_if.address = 16'h0; host_if.writedata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL reset_level got %0d want 0", level); end
        vectors++; if (tbl_we !== 3'b000) begin miscompares++; $display("FAIL reset_we got %b want 000", tbl_we); end
        vectors++; if (tbl_addr !== 8'h00) begin miscompares++; $display("FAIL reset_addr got %h want 00", tbl_addr); end
        vectors++; if (tbl_data !== 32'h0) begin miscompares++; $display("FAIL reset_data got %h want 0", tbl_data); end
        vectors++; if (bad_addr !== 1'b0) begin miscompares++; $display("FAIL reset_bad got %b want 0", bad_addr); end
        vectors++; if (host_if.waitrequest !== 1'b0) begin miscompares++; $display("FAIL reset_wait got %b want 0", host_if.waitrequest); end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_basic();
        @(posedge clk); #1 vcount = 10'd100;
        host_write(16'h0105, 32'hDEADBEEF);
        repeat (5) @(negedge clk);
        vectors++; if (obs.size() != 0) begin miscompares++; $display("FAIL basic_outside got %0d pulses want 0", obs.size()); end
        vectors++; if (level !== 5'd1) begin miscompares++; $display("FAIL basic_level got %0d want 1", level); end
        @(posedge clk); #1 vcount = 10'd479;
        repeat (4) @(negedge clk);
        vectors++; if (obs.size() != 0) begin miscompares++; $display("FAIL basic_479 got %0d pulses want 0", obs.size()); end
        @(posedge clk); #1 vcount = 10'd480;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (tbl_we !== 3'b010) begin miscompares++; $display("FAIL basic_we got %b want 010", tbl_we); end
        vectors++; if (tbl_addr !== 8'h05) begin miscompares++; $display("FAIL basic_addr got %h want 05", tbl_addr); end
        vectors++; if (tbl_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL basic_data got %h want deadbeef", tbl_data); end
        vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL basic_level_after got %0d want 0", level); end
        @(negedge clk);
        vectors++; if (tbl_we !== 3'b000) begin miscompares++; $display("FAIL basic_one_cycle got %b want 000", tbl_we); end
        vectors++; if (tbl_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL basic_hold got %h want deadbeef", tbl_data); end
        vectors++; if (obs.size() != 1) begin miscompares++; $display("FAIL basic_count got %0d want 1", obs.size()); end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_latency();
        @(posedge clk); #1 vcount = 10'd480;
        host_if.chipselect = 1'b1; host_if.write = 1'b1;
        host_if.address = 16'h0012; host_if.writedata = 32'h1234_5678;
        @(posedge clk); #1;
        host_if.chipselect = 1'b0; host_if.write = 1'b0;
        @(negedge clk);
        vectors++; if (tbl_we !== 3'b000) begin miscompares++; $display("FAIL lat_t1_we got %b want 000", tbl_we); end
        vectors++; if (level !== 5'd1) begin miscompares++; $display("FAIL lat_t1_level got %0d want 1", level); end
        @(negedge clk);
        vectors++; if (tbl_we !== 3'b001) begin miscompares++; $display("FAIL lat_t2_we got %b want 001", tbl_we); end
        vectors++; if (tbl_addr !== 8'h12) begin miscompares++; $display("FAIL lat_t2_addr got %h want 12", tbl_addr); end
        vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL lat_t2_level got %0d want 0", level); end
        @(negedge clk);
        vectors++; if (tbl_we !== 3'b000) begin miscompares++; $display("FAIL lat_t3_we got %b want 000", tbl_we); end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_full();
        @(posedge clk); #1 vcount = 10'd100;
        fill16(32'hA000_0000);
        @(negedge clk);
        vectors++; if (level !== 5'd16) begin miscompares++; $display("FAIL full_level got %0d want 16", level); end
        vectors++; if (host_if.waitrequest !== 1'b1) begin miscompares++; $display("FAIL full_wait got %b want 1", host_if.waitrequest); end
        @(posedge clk); #1;
        host_if.chipselect = 1'b1; host_if.write = 1'b1;
        host_if.address = 16'h02AA; host_if.writedata = 32'hBBBB_0017;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (level !== 5'd16 || host_if.waitrequest !== 1'b1) begin
            miscompares++; $display("FAIL full_held level=%0d wait=%b want 16/1", level, host_if.waitrequest);
        end
        vcount = 10'd480;
        @(posedge clk);
        @(negedge clk);
        // A pop at full must not let the stalled write in on the same edge.
        vectors++; if (level !== 5'd15) begin miscompares++; $display("FAIL full_pop_no_accept level got %0d want 15", level); end
        vectors++; if (host_if.waitrequest !== 1'b0) begin miscompares++; $display("FAIL full_release got %b want 0", host_if.waitrequest); end
        @(posedge clk); #1;
        host_if.chipselect = 1'b0; host_if.write = 1'b0;
        exp_q.push_back(mk(16'h02AA, 32'hBBBB_0017));
        wait_idle();
        vectors++; if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL full_count got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= obs.size() || obs[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL full_order[%0d] got %h want %h", i, (i < obs.size()) ? obs[i] : 43'h0, exp_q[i]);
            end
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_window_exit();
        @(posedge clk); #1 vcount = 10'd100;
        fill16(32'hC000_0000);
        @(posedge clk); #1 vcount = 10'd523;
        repeat (5) @(posedge clk);
        #1 vcount = 10'd524;
        repeat (5) @(negedge clk);
        vectors++; if (obs.size() != 5) begin miscompares++; $display("FAIL exit_pulses got %0d want 5", obs.size()); end
        vectors++; if (level !== 5'd11) begin miscompares++; $display("FAIL exit_level got %0d want 11", level); end
        @(posedge clk); #1 vcount = 10'd0;
        repeat (5) @(negedge clk);
        vectors++; if (obs.size() != 5) begin miscompares++; $display("FAIL exit_line0 got %0d want 5", obs.size()); end
        @(posedge clk); #1 vcount = 10'd480;
        wait_idle();
        vectors++; if (obs.size() != 16) begin miscompares++; $display("FAIL exit_total got %0d want 16", obs.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= obs.size() || obs[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL exit_order[%0d] got %h want %h", i, (i < obs.size()) ? obs[i] : 43'h0, exp_q[i]);
            end
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_bad_addr();
        @(posedge clk); #1 vcount = 10'd100;
        host_write(16'h0300, 32'h5555_5555);
        @(negedge clk);
        vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL bad_level got %0d want 0", level); end
        vectors++; if (bad_addr !== 1'b1) begin miscompares++; $display("FAIL bad_set got %b want 1", bad_addr); end
        @(posedge clk); #1 clear_err = 1'b1;
        @(posedge clk); #1 clear_err = 1'b0;
        @(negedge clk);
        vectors++; if (bad_addr !== 1'b0) begin miscompares++; $display("FAIL bad_clear got %b want 0", bad_addr); end
        @(posedge clk); #1;
        host_if.chipselect = 1'b1; host_if.write = 1'b1;
        host_if.address = 16'h0300; host_if.writedata = 32'h6666_6666;
        clear_err = 1'b1;
        @(posedge clk); #1;
        host_if.chipselect = 1'b0; host_if.write = 1'b0; clear_err = 1'b0;
        @(negedge clk);
        vectors++; if (bad_addr !== 1'b1) begin miscompares++; $display("FAIL bad_priority got %b want 1", bad_addr); end
        vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL bad_level2 got %0d want 0", level); end
        @(posedge clk); #1 clear_err = 1'b1;
        @(posedge clk); #1 clear_err = 1'b0;
        vectors++; if (obs.size() != 0) begin miscompares++; $display("FAIL bad_pulses got %0d want 0", obs.size()); end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_drain();
        @(posedge clk); #1 vcount = 10'd100;
        fill16(32'hD000_0000);
        @(posedge clk); #1 vcount = 10'd480;
        repeat (8) @(posedge clk);
        @(negedge clk);
        vectors++; if (level !== 5'd8) begin miscompares++; $display("FAIL rst_pre_level got %0d want 8", level); end
        reset = 1'b1;
        #1;
        vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL rst_level got %0d want 0", level); end
        vectors++; if (tbl_we !== 3'b000) begin miscompares++; $display("FAIL rst_we got %b want 000", tbl_we); end
        vectors++; if (tbl_data !== 32'h0) begin miscompares++; $display("FAIL rst_data got %h want 0", tbl_data); end
        obs.delete(); exp_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        repeat (20) @(negedge clk);
        vectors++; if (obs.size() != 0) begin miscompares++; $display("FAIL rst_no_pulse got %0d want 0", obs.size()); end
        vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL rst_after_level got %0d want 0", level); end
        obs.delete();
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1 vcount = 10'd100;
        host_write(16'h0001, 32'h1111_0001); exp_q.push_back(mk(16'h0001, 32'h1111_0001));
        host_write(16'h0102, 32'h1111_0002); exp_q.push_back(mk(16'h0102, 32'h1111_0002));
        host_write(16'h0203, 32'h1111_0003); exp_q.push_back(mk(16'h0203, 32'h1111_0003));
        vcount = 10'd480;
        host_if.chipselect = 1'b1; host_if.write = 1'b1;
        host_if.address = 16'h0204; host_if.writedata = 32'h1111_0004;
        @(negedge clk);
        vectors++; if (level !== 5'd3) begin miscompares++; $display("FAIL b2b_pre_level got %0d want 3", level); end
        @(posedge clk); #1;
        host_if.chipselect = 1'b0; host_if.write = 1'b0;
        exp_q.push_back(mk(16'h0204, 32'h1111_0004));
        @(negedge clk);
        vectors++; if (level !== 5'd3) begin miscompares++; $display("FAIL b2b_level got %0d want 3", level); end
        wait_idle();
        vectors++; if (obs.size() != 4) begin miscompares++; $display("FAIL b2b_count got %0d want 4", obs.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= obs.size() || obs[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL b2b_order[%0d] got %h want %h", i, (i < obs.size()) ? obs[i] : 43'h0, exp_q[i]);
            end
        end
        obs.delete(); exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_full();
        test_window_exit();
        test_bad_addr();
        test_reset_mid_drain();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
